tcdm_burst_initiator: RTL and testbench
=======================================

TCDM_BURST_INITIATOR -- requirements
Module: tcdm_burst_initiator

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, max granted-but-unanswered transactions (1..15).
REQ-002 SHALL have parameter LEN_W, default 16, width of burst-length and index counters.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports start_i (in, 1, one-cycle start pulse), rd_i (in, 1, 1=read burst, 0=write burst), base_i (in, 32, byte base address), stride_i (in, 32, byte stride), len_i (in, LEN_W, word count), seed_i (in, 32, data pattern seed).
REQ-006 SHALL have ports busy_o (out, 1), done_o (out, 1, one-cycle pulse), err_o (out, 1, sticky protocol error), mismatch_cnt_o (out, 16, read mismatches).
REQ-007 SHALL have TCDM initiator ports: tcdm_req_o (out, 1), tcdm_gnt_i (in, 1), tcdm_add_o (out, 32), tcdm_wen_o (out, 1, 1=read), tcdm_be_o (out, 4), tcdm_data_o (out, 32), tcdm_r_data_i (in, 32), tcdm_r_valid_i (in, 1).

Function
REQ-008 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
REQ-009 IDLE: on start_i, SHALL latch all config inputs, clear index, response and mismatch counters and err_o, then go to ISSUE; if len_i==0, go directly to DONE.
REQ-010 start_i outside IDLE SHALL be ignored.
REQ-011 Transaction k (0..len-1) SHALL use address base+k*stride (mod 2^32), be=4'hF, wen=rd, write data seed+k (mod 2^32).
REQ-012 In ISSUE, tcdm_req_o SHALL be asserted when outstanding < MAX_OUTSTANDING or a request is already pending.
REQ-013 Once asserted, tcdm_req_o and add/wen/be/data SHALL stay stable until the cycle tcdm_gnt_i is high.
REQ-014 Handshake: a transfer occurs in each cycle with req&gnt; index increments; after index len-1 is granted, FSM goes to DRAIN the next cycle.
REQ-015 Back-to-back issue SHALL be supported: one request per cycle while gnt stays high and the outstanding limit allows.
REQ-016 Outstanding counter: +1 on req&gnt, -1 on r_valid, unchanged on both simultaneously.
REQ-017 r_valid with outstanding==0 and no simultaneous grant SHALL set err_o (sticky until next start); the counter SHALL stay 0.
REQ-018 Both reads and writes SHALL expect exactly one r_valid response each.
REQ-019 DRAIN SHALL move to DONE in the cycle after outstanding reaches 0.
REQ-020 DONE SHALL last one cycle, assert done_o, and return to IDLE.
REQ-021 busy_o SHALL be high in ISSUE and DRAIN.
REQ-022 tcdm_add_o, tcdm_data_o and tcdm_be_o SHALL be 0 when tcdm_req_o is low.

Reset
REQ-023 rst_i SHALL asynchronously force state IDLE, all counters 0, req/busy/done/err 0, add/data/be 0, wen 1, mismatch_cnt_o 0.
REQ-024 Reset mid-burst SHALL abandon the burst; responses arriving after reset deassertion with outstanding==0 SHALL set err_o.

Configuration
REQ-025 Macro TCDM_INIT_CHECK_EN: when defined, the j-th read response SHALL be compared with seed+j, and mismatch_cnt_o SHALL increment per mismatch, saturating at 16'hFFFF.
REQ-026 Without TCDM_INIT_CHECK_EN: no compare logic; mismatch_cnt_o SHALL be tied to 0; write responses are never checked in either case.

Structure
REQ-027 Package tcdm_init_pkg SHALL hold the FSM state enum and the default constants (MAX_OUTSTANDING, LEN_W, full byte-enable).
REQ-028 Outstanding counter and underflow detection SHALL be the sub-module tcdm_init_outstanding_cnt; all other logic stays flat.

Verification
REQ-029 Write burst: base=0x1000, stride=4, len=8, seed=0xA0, target always grants -> 8 grants, addresses 0x1000..0x101C, data 0xA0..0xA7, done_o 1 cycle after last r_valid.
REQ-030 Read-back: same config with rd=1 against memory holding the previous writes -> mismatch_cnt_o=0; corrupting word 3 -> mismatch_cnt_o=1.
REQ-031 Random stalls at 50% -> req/add/data stable while gnt=0, no lost or duplicated addresses, 8 responses counted.
REQ-032 Response delay of 6 cycles with MAX_OUTSTANDING=4 -> never more than 4 outstanding; req low while the limit is reached.
REQ-033 len=0 -> done_o 1 cycle after start, no req; spurious r_valid in IDLE -> err_o=1.
REQ-034 rst_i asserted during ISSUE at k=3 -> all outputs return to reset values immediately; a new start afterwards completes normally.

Source files
------------

// File: rtl/tcdm_init_pkg.sv
// Shared types and defaults for the TCDM burst initiator: FSM state encoding,
// default parameter values, full byte-enable and the saturating counter helper.
package tcdm_init_pkg;

  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned DEF_LEN_W           = 16;
  localparam int unsigned OUT_CNT_W           = 4;
  localparam logic [3:0]  BE_FULL             = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/tcdm_init_outstanding_cnt.sv
// Granted-but-unanswered transaction counter with underflow detection
// (a response arriving while nothing is outstanding and nothing is being granted).
module tcdm_init_outstanding_cnt
  import tcdm_init_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  output logic [OUT_CNT_W-1:0] cnt_next,
  output logic                 underflow
);

  logic [OUT_CNT_W-1:0] cnt_r;

  // next count; an unmatched response leaves the counter at zero and flags it
  always_comb begin
    cnt_next  = cnt_r;
    underflow = 1'b0;
    if (inc && !dec) begin
      cnt_next = cnt_r + OUT_CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt_r == '0) begin
        underflow = 1'b1;
      end else begin
        cnt_next = cnt_r - OUT_CNT_W'(1);
      end
    end else begin
      cnt_next = cnt_r;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next;
    end
  end

endmodule

// File: rtl/tcdm_burst_initiator.sv
// Strided TCDM burst initiator (reads or writes, seed+k data pattern).
// Optional read-data checking is enabled with the macro TCDM_INIT_CHECK_EN.
module tcdm_burst_initiator
  import tcdm_init_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int unsigned LEN_W           = DEF_LEN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             rd_i,
  input  logic [31:0]      base_i,
  input  logic [31:0]      stride_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      seed_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [15:0]      mismatch_cnt_o,
  output logic             tcdm_req_o,
  input  logic             tcdm_gnt_i,
  output logic [31:0]      tcdm_add_o,
  output logic             tcdm_wen_o,
  output logic [3:0]       tcdm_be_o,
  output logic [31:0]      tcdm_data_o,
  input  logic [31:0]      tcdm_r_data_i,
  input  logic             tcdm_r_valid_i
);

  state_e               state, state_next;
  logic [LEN_W-1:0]     len_q, idx, idx_next;
  logic [31:0]          stride_q;
  logic [31:0]          addr_acc, addr_acc_next;
  logic [31:0]          data_acc, data_acc_next;
  logic                 req_next, busy_next, done_next, err_next;
  logic                 fire, start_acc, room;
  logic [OUT_CNT_W-1:0] out_cnt_next;
  logic                 underflow;

  assign fire      = tcdm_req_o & tcdm_gnt_i;
  assign start_acc = (state == ST_IDLE) & start_i;
  // room is judged on the count that will hold while the new request is visible
  assign room      = (out_cnt_next < OUT_CNT_W'(MAX_OUTSTANDING));

  tcdm_init_outstanding_cnt u_out_cnt (
    .clk       (clk_i),
    .rst       (rst_i),
    .inc       (fire),
    .dec       (tcdm_r_valid_i),
    .cnt_next  (out_cnt_next),
    .underflow (underflow)
  );

  // next state, transaction index and the request for the coming cycle
  always_comb begin
    state_next    = state;
    idx_next      = idx;
    addr_acc_next = addr_acc;
    data_acc_next = data_acc;
    req_next      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          idx_next      = '0;
          addr_acc_next = base_i;
          data_acc_next = seed_i;
          if (len_i == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ISSUE;
            req_next   = room;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (fire) begin
          idx_next      = idx + LEN_W'(1);
          addr_acc_next = addr_acc + stride_q;
          data_acc_next = data_acc + 32'd1;
          if (idx == (len_q - LEN_W'(1))) begin
            state_next = ST_DRAIN;
            req_next   = 1'b0;
          end else begin
            req_next = room;
          end
        end else if (tcdm_req_o) begin
          req_next = 1'b1;
        end else begin
          req_next = room;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_next == '0) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next == ST_ISSUE) || (state_next == ST_DRAIN);
    done_next = (state_next == ST_DONE);
    err_next  = start_acc ? underflow : (err_o | underflow);
  end

  // FSM, burst configuration and registered bus outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      idx         <= '0;
      len_q       <= '0;
      stride_q    <= 32'd0;
      addr_acc    <= 32'd0;
      data_acc    <= 32'd0;
      tcdm_req_o  <= 1'b0;
      tcdm_add_o  <= 32'd0;
      tcdm_data_o <= 32'd0;
      tcdm_be_o   <= 4'h0;
      tcdm_wen_o  <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      addr_acc <= addr_acc_next;
      data_acc <= data_acc_next;
      if (start_acc) begin
        len_q      <= len_i;
        stride_q   <= stride_i;
        tcdm_wen_o <= rd_i;
      end
      tcdm_req_o  <= req_next;
      tcdm_add_o  <= req_next ? addr_acc_next : 32'd0;
      tcdm_data_o <= req_next ? data_acc_next : 32'd0;
      tcdm_be_o   <= req_next ? BE_FULL : 4'h0;
      busy_o      <= busy_next;
      done_o      <= done_next;
      err_o       <= err_next;
    end
  end

`ifdef TCDM_INIT_CHECK_EN
  logic [31:0] chk_acc;
  logic [15:0] mm_cnt;
  logic        rsp_chk;

  assign rsp_chk = tcdm_r_valid_i & tcdm_wen_o &
                   ((state == ST_ISSUE) || (state == ST_DRAIN));

  // read responses arrive in order, so the j-th one is compared with seed+j
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chk_acc <= 32'd0;
      mm_cnt  <= 16'd0;
    end else if (start_acc) begin
      chk_acc <= seed_i;
      mm_cnt  <= 16'd0;
    end else if (rsp_chk) begin
      chk_acc <= chk_acc + 32'd1;
      if (tcdm_r_data_i != chk_acc) begin
        mm_cnt <= sat_inc16(mm_cnt);
      end else begin
        mm_cnt <= mm_cnt;
      end
    end else begin
      chk_acc <= chk_acc;
      mm_cnt  <= mm_cnt;
    end
  end

  assign mismatch_cnt_o = mm_cnt;
`else
  logic unused_rdata;
  assign unused_rdata   = ^tcdm_r_data_i;
  assign mismatch_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_tcdm_burst_initiator.sv
// Bench for tcdm_burst_initiator: table of bursts against a memory/target model
// with a grant/response scoreboard, plus len=0, spurious response and reset cases.
`timescale 1ns/1ps
module tb_tcdm_burst_initiator;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst, start, rd, busy, done, err, req, gnt, wen, r_valid;
  logic [31:0] base, stride, seed, add, wdata, rdata;
  logic [15:0] len, mm_cnt;
  logic [3:0]  be;

  always #5 clk = ~clk;

  tcdm_burst_initiator dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .rd_i(rd), .base_i(base),
    .stride_i(stride), .len_i(len), .seed_i(seed), .busy_o(busy), .done_o(done),
    .err_o(err), .mismatch_cnt_o(mm_cnt), .tcdm_req_o(req), .tcdm_gnt_i(gnt),
    .tcdm_add_o(add), .tcdm_wen_o(wen), .tcdm_be_o(be), .tcdm_data_o(wdata),
    .tcdm_r_data_i(rdata), .tcdm_r_valid_i(r_valid)
  );

  typedef struct {
    logic rd; logic [31:0] base; logic [31:0] stride; int len; logic [31:0] seed;
    int gnt_pct; int delay; int corrupt; int exp_mm; int exp_max;
  } vec_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic wen; } txn_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;

  vec_t        vecs [8];
  txn_t        exp_q [$];
  rsp_t        rsp_q [$];
  logic [31:0] mem [logic [31:0]];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, gnt_pct = 100, delay = 1;
  int grants, resps, done_cnt, done_cyc, last_rv_cyc, out_tb, max_out;
  logic        pend;
  logic [31:0] held_add, held_data;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // target model: samples the bus mid-cycle, drives gnt/r_valid just after the edge
  task automatic bus_model();
    txn_t t;
    rsp_t r;
    logic f, rv;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        out_tb = 0;
        pend   = 1'b0;
      end else begin
        f  = req & gnt;
        rv = r_valid;
        if (pend) begin
          chk1("hold_req", req, 1'b1);
          chk32("hold_add", add, held_add);
          chk32("hold_data", wdata, held_data);
        end
        pend      = req & ~gnt;
        held_add  = add;
        held_data = wdata;
        if (!req) begin
          chk32("idle_add", add, 32'h0);
          chk32("idle_data", wdata, 32'h0);
          chk32("idle_be", 32'(be), 32'h0);
        end
        chk1("out_le_max", out_tb <= MAXO, 1'b1);
        if (out_tb == MAXO) chk1("req_at_limit", req, 1'b0);
        if (f) begin
          grants++;
          chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            t = exp_q.pop_front();
            chk32("grant_addr", add, t.addr);
            chk1("grant_wen", wen, t.wen);
            chk32("grant_be", 32'(be), 32'hF);
            if (!t.wen) chk32("grant_wdata", wdata, t.data);
          end
          r.due  = cyc + delay;
          r.data = (wen && mem.exists(add)) ? mem[add] : 32'h0;
          if (!wen) mem[add] = wdata;
          rsp_q.push_back(r);
        end
        if (rv) begin
          resps++;
          last_rv_cyc = cyc;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (f && !rv) out_tb++;
        else if (rv && !f && out_tb > 0) out_tb--;
        if (out_tb > max_out) max_out = out_tb;
      end
      @(posedge clk);
      #1;
      gnt = ($urandom_range(0, 99) < gnt_pct);
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc + 1) begin
        r       = rsp_q.pop_front();
        r_valid = 1'b1;
        rdata   = r.data;
      end else begin
        r_valid = 1'b0;
        rdata   = $urandom;
      end
    end
  endtask

  task automatic load_exp(input vec_t v);
    txn_t t;
    exp_q.delete();
    for (int k = 0; k < v.len; k++) begin
      t.addr = v.base + v.stride * k;
      t.data = v.seed + k;
      t.wen  = v.rd;
      exp_q.push_back(t);
    end
    gnt_pct = v.gnt_pct;
    delay   = v.delay;
    grants = 0; resps = 0; done_cnt = 0; max_out = 0;
  endtask

  task automatic drive_start(input vec_t v);
    start = 1'b1; rd = v.rd; base = v.base; stride = v.stride;
    len = 16'(v.len); seed = v.seed;
    step();
    start = 1'b0;
  endtask

  task automatic run_burst(input vec_t v, input string tag);
    logic [31:0] a;
    int t, exp_mm;
    if (v.corrupt >= 0) begin
      a = v.base + v.stride * v.corrupt;
      mem[a] = mem[a] ^ 32'h0000_0100;
    end
    load_exp(v);
    step();
    drive_start(v);
    chk1({tag, "_busy"}, busy, 1'b1);
    start = 1'b1; len = 16'd1; base = 32'hDEAD_0000;
    step();
    start = 1'b0;
    t = 0;
    while (done_cnt == 0 && t < 3000) begin
      step();
      t++;
    end
    chk1({tag, "_done_seen"}, done_cnt != 0, 1'b1);
    chk32({tag, "_grants"}, 32'(grants), 32'(v.len));
    chk32({tag, "_resps"}, 32'(resps), 32'(v.len));
    chk32({tag, "_done_lat"}, 32'(done_cyc), 32'(last_rv_cyc + 1));
    chk32({tag, "_sb_left"}, 32'(exp_q.size()), 32'h0);
    chk1({tag, "_err"}, err, 1'b0);
    chk1({tag, "_busy_end"}, busy, 1'b0);
`ifdef TCDM_INIT_CHECK_EN
    exp_mm = v.exp_mm;
`else
    exp_mm = 0;
`endif
    chk32({tag, "_mismatch"}, 32'(mm_cnt), 32'(exp_mm));
    if (v.exp_max != 0) chk32({tag, "_max_out"}, 32'(max_out), 32'(v.exp_max));
    step();
    chk32({tag, "_done_pulses"}, 32'(done_cnt), 32'h1);
    chk1({tag, "_done_low"}, done, 1'b0);
  endtask

  initial begin
    vec_t  v;
    rsp_t  r;
    int    t;
    rst = 1'b1; start = 1'b0; rd = 1'b0; base = 32'h0; stride = 32'h0; len = 16'h0;
    seed = 32'h0; gnt = 1'b0; r_valid = 1'b0; rdata = 32'h0;
    vecs[0] = '{1'b0, 32'h0000_1000, 32'd4, 8,  32'h0000_00A0, 100, 1, -1, 0, 0};
    vecs[1] = '{1'b1, 32'h0000_1000, 32'd4, 8,  32'h0000_00A0, 100, 1, -1, 0, 0};
    vecs[2] = '{1'b1, 32'h0000_1000, 32'd4, 8,  32'h0000_00A0, 100, 1,  3, 1, 0};
    vecs[3] = '{1'b0, 32'h0000_2000, 32'd8, 8,  32'h0000_0055,  50, 2, -1, 0, 0};
    vecs[4] = '{1'b1, 32'h0000_2000, 32'd8, 8,  32'h0000_0055,  50, 3, -1, 0, 0};
    vecs[5] = '{1'b0, 32'h0000_3000, 32'd4, 12, 32'h0000_0007, 100, 6, -1, 0, 4};
    vecs[6] = '{1'b0, 32'hFFFF_FFF8, 32'd4, 4,  32'hFFFF_FFFE,  50, 6, -1, 0, 0};
    vecs[7] = '{1'b1, 32'hFFFF_FFF8, 32'd4, 4,  32'hFFFF_FFFE, 100, 6, -1, 0, 4};
    fork
      bus_model();
    join_none

    repeat (3) @(posedge clk);
    #2;
    chk1("rst_req", req, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_wen", wen, 1'b1);
    chk32("rst_add", add, 32'h0);
    chk32("rst_mm", 32'(mm_cnt), 32'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_burst(vecs[i], $sformatf("vec%0d", i));

    // zero-length burst completes immediately without touching the bus
    v = '{1'b0, 32'h0000_4000, 32'd4, 0, 32'h0, 100, 1, -1, 0, 0};
    load_exp(v);
    step();
    drive_start(v);
    chk1("len0_done", done, 1'b1);
    chk1("len0_req", req, 1'b0);
    chk1("len0_busy", busy, 1'b0);
    step();
    chk1("len0_done_pulse", done, 1'b0);
    chk32("len0_grants", 32'(grants), 32'h0);

    // unsolicited response while idle
    chk1("pre_spur_err", err, 1'b0);
    r.due  = cyc + 2;
    r.data = 32'h0;
    rsp_q.push_back(r);
    repeat (4) step();
    chk1("spur_err", err, 1'b1);

    // reset while transaction k=3 is presented, stale responses afterwards
    v = '{1'b0, 32'h0000_5000, 32'd4, 8, 32'h0000_0011, 100, 6, -1, 0, 0};
    load_exp(v);
    step();
    drive_start(v);
    t = 0;
    while (grants < 3 && t < 200) begin
      step();
      t++;
    end
    chk32("mid_grants", 32'(grants), 32'h3);
    chk1("mid_req_before", req, 1'b1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_req", req, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk1("mid_rst_err", err, 1'b0);
    chk1("mid_rst_wen", wen, 1'b1);
    chk32("mid_rst_add", add, 32'h0);
    chk32("mid_rst_data", wdata, 32'h0);
    chk32("mid_rst_be", 32'(be), 32'h0);
    chk32("mid_rst_mm", 32'(mm_cnt), 32'h0);
    repeat (2) step();
    rst = 1'b0;
    exp_q.delete();
    t = 0;
    while (rsp_q.size() != 0 && t < 50) begin
      step();
      t++;
    end
    repeat (2) step();
    chk1("stale_rsp_err", err, 1'b1);
    v = '{1'b0, 32'h0000_6000, 32'd4, 6, 32'h0000_0033, 100, 2, -1, 0, 0};
    run_burst(v, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
